// File: rtl/mano_mem_arbiter_pkg.sv
// Shared types and constants for the Mano memory arbiter.
//   arb_state_e : arbiter FSM state encoding (2-bit)
//   owner_e     : which requester owns the current access
//   DEF_AW/DW   : default address/data widths (4K x 16 word space)
//   cnt_width() : minimum register width able to hold 0..max_val
package mano_mem_arbiter_pkg;

   localparam int DEF_AW = 12;
   localparam int DEF_DW = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_CORE = 1'b0,
      OWN_DMA  = 1'b1
   } owner_e;

   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mano_mem_lat_cnt.sv
// Access-latency timer: loadable down-counter with a terminal-count flag.
//   i_clk      : clock
//   i_rst_n    : asynchronous active-low reset (count -> 0)
//   i_load     : load i_load_val (takes priority over decrement)
//   i_load_val : start value, number of remaining cycles minus one
//   i_dec      : decrement by one while non-zero
//   o_last     : count is at zero, i.e. the current cycle is the last one
module mano_mem_lat_cnt #(
   parameter int CW = 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_load,
   input  logic [CW-1:0] i_load_val,
   input  logic          i_dec,
   output logic          o_last
);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_last = (r_cnt == '0);

endmodule

// File: rtl/mano_mem_arbiter.sv
// Shares the single memory port between the core and the DMA/program loader.
// Each access: arbitrate in IDLE, drive mem_en for MEM_LAT cycles, then give
// the owner a one-cycle ready/ack. Core has fixed priority, except that a
// pending DMA request wins once MAX_WAIT consecutive core grants have been
// made while it waited.
//
// Ports:
//   mclk, mrst                 clock, async active-low reset
//   cpu_rd/cpu_wr/addr/wdata   core request (level, held until cpu_ready)
//   cpu_rdata, cpu_ready       core read data, one-cycle completion
//   dma_req/we/addr/wdata      DMA request (level, held until dma_ack)
//   dma_rdata, dma_ack         DMA read data, one-cycle completion
//   mem_en/we/addr/wdata       memory port, all registered
//   mem_rdata                  memory read data, valid in last access cycle
//   busy                       access in progress (ACCESS or RESP)
//   proto_err                  sticky: core asserted rd and wr together
//
// state  | meaning
// IDLE   | arbitrate on each edge, latch winner's operands
// ACCESS | mem_en high, MEM_LAT cycles, capture read data on last edge
// RESP   | owner's ready/ack high for one cycle
module mano_mem_arbiter
   import mano_mem_arbiter_pkg::*;
#(
   parameter int AW       = DEF_AW,
   parameter int DW       = DEF_DW,
   parameter int MEM_LAT  = 2,
   parameter int MAX_WAIT = 4
) (
   input  logic          mclk,
   input  logic          mrst,
   input  logic          cpu_rd,
   input  logic          cpu_wr,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ready,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic [DW-1:0] dma_rdata,
   output logic          dma_ack,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          proto_err
);

   localparam int SW = cnt_width(MAX_WAIT);
   localparam int CW = cnt_width(MEM_LAT - 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);
   localparam logic [CW-1:0] LAT_LOAD   = CW'(MEM_LAT - 1);

   arb_state_e    r_state;
   owner_e        r_owner;
   logic [SW-1:0] r_starve_cnt;

   logic w_core_req;
   logic w_dma_win;
   logic w_core_win;
   logic w_grant;
   logic w_last;

   assign w_core_req = cpu_rd | cpu_wr;
   // DMA overrides core priority only once the starvation count saturates.
   assign w_dma_win  = dma_req & (~w_core_req | (r_starve_cnt == STARVE_MAX));
   assign w_core_win = w_core_req & ~w_dma_win;
   assign w_grant    = (r_state == ST_IDLE) & (w_core_req | dma_req);

   mano_mem_lat_cnt #(
      .CW (CW)
   ) u_lat_cnt (
      .i_clk      (mclk),
      .i_rst_n    (mrst),
      .i_load     (w_grant),
      .i_load_val (LAT_LOAD),
      .i_dec      (r_state == ST_ACCESS),
      .o_last     (w_last)
   );

   always_ff @(posedge mclk or negedge mrst) begin
      if (!mrst) begin
         r_state      <= ST_IDLE;
         r_owner      <= OWN_CORE;
         r_starve_cnt <= '0;
         cpu_rdata    <= '0;
         cpu_ready    <= 1'b0;
         dma_rdata    <= '0;
         dma_ack      <= 1'b0;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         busy         <= 1'b0;
         proto_err    <= 1'b0;
      end else begin
         cpu_ready <= 1'b0;
         dma_ack   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!dma_req || w_dma_win) begin
                  r_starve_cnt <= '0;
               end else if (r_starve_cnt != STARVE_MAX) begin
                  r_starve_cnt <= r_starve_cnt + 1'b1;
               end
               if (w_core_win) begin
                  r_owner   <= OWN_CORE;
                  mem_addr  <= cpu_addr;
                  mem_wdata <= cpu_wdata;
                  // rd+wr together is performed as a write
                  mem_we    <= cpu_wr;
                  mem_en    <= 1'b1;
                  busy      <= 1'b1;
                  r_state   <= ST_ACCESS;
                  if (cpu_rd && cpu_wr) begin
                     proto_err <= 1'b1;
                  end
               end else if (w_dma_win) begin
                  r_owner   <= OWN_DMA;
                  mem_addr  <= dma_addr;
                  mem_wdata <= dma_wdata;
                  mem_we    <= dma_we;
                  mem_en    <= 1'b1;
                  busy      <= 1'b1;
                  r_state   <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (w_last) begin
                  mem_en  <= 1'b0;
                  mem_we  <= 1'b0;
                  r_state <= ST_RESP;
                  if (r_owner == OWN_CORE) begin
                     cpu_ready <= 1'b1;
                     if (!mem_we) begin
                        cpu_rdata <= mem_rdata;
                     end
                  end else begin
                     dma_ack <= 1'b1;
                     if (!mem_we) begin
                        dma_rdata <= mem_rdata;
                     end
                  end
               end
            end
            ST_RESP: begin
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               mem_en  <= 1'b0;
               mem_we  <= 1'b0;
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mano_mem_arbiter.sv
module tb_mano_mem_arbiter;

   localparam int AW       = 12;
   localparam int DW       = 16;
   localparam int MEM_LAT  = 2;
   localparam int MAX_WAIT = 4;

   logic          mclk = 1'b0;
   logic          mrst = 1'b0;
   logic          cpu_rd = 1'b0, cpu_wr = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ready;
   logic          dma_req = 1'b0, dma_we = 1'b0;
   logic [AW-1:0] dma_addr = '0;
   logic [DW-1:0] dma_wdata = '0;
   logic [DW-1:0] dma_rdata;
   logic          dma_ack;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          busy, proto_err;

   mano_mem_arbiter #(
      .AW (AW), .DW (DW), .MEM_LAT (MEM_LAT), .MAX_WAIT (MAX_WAIT)
   ) dut (
      .mclk (mclk), .mrst (mrst),
      .cpu_rd (cpu_rd), .cpu_wr (cpu_wr), .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata), .cpu_ready (cpu_ready),
      .dma_req (dma_req), .dma_we (dma_we), .dma_addr (dma_addr), .dma_wdata (dma_wdata),
      .dma_rdata (dma_rdata), .dma_ack (dma_ack),
      .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata), .busy (busy), .proto_err (proto_err)
   );

   always #5 mclk = ~mclk;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } txn_t;

   txn_t          cpu_q[$];
   txn_t          dma_q[$];
   logic [DW-1:0] ref_mem [int];
   int            n_chk = 0;
   int            n_pass = 0;

   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      if (a == 12'h0A5) return 16'h1234;
      return {a[3:0], a} ^ 16'h5A3C;
   endfunction

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // memory device: data only valid in the last enabled cycle, write commits on that edge
   logic [DW-1:0] mem_dev [4096];
   logic          mem_vld [4096] = '{default: 1'b0};
   int            en_cnt;

   always @(posedge mclk or negedge mrst) begin
      if (!mrst) begin
         en_cnt <= 0;
      end else if (mem_en) begin
         if (en_cnt == MEM_LAT - 1) begin
            en_cnt <= 0;
            if (mem_we) begin
               mem_dev[mem_addr] <= mem_wdata;
               mem_vld[mem_addr] <= 1'b1;
            end
         end else begin
            en_cnt <= en_cnt + 1;
         end
      end else begin
         en_cnt <= 0;
      end
   end

   function automatic logic [DW-1:0] dev_rd(input logic [AW-1:0] a);
      return mem_vld[a] ? mem_dev[a] : init_val(a);
   endfunction

   always_comb begin
      mem_rdata = 16'hDEAD;
      if (mem_en && (en_cnt == MEM_LAT - 1)) mem_rdata = dev_rd(mem_addr);
   end

   // monitor + reference arbitration model
   bit            mon_en = 1'b0;
   int            cyc = 0, en_len = 0, g_cyc = 0, m_starve = 0, streak = 0, last_streak = 0;
   logic          p_cpu = 1'b0, p_dma = 1'b0, prev_en = 1'b0, g_dma = 1'b0, exp_dma;
   logic          addr_moved = 1'b0;
   logic [AW-1:0] win_addr = '0;
   txn_t          t_m;

   initial begin
      forever begin
         @(negedge mclk);
         cyc++;
         if (!mon_en) begin
            prev_en = 1'b0; en_len = 0; p_cpu = 1'b0; p_dma = 1'b0;
         end else begin
            chk("busy", 32'(busy), 32'(mem_en | cpu_ready | dma_ack));
            if (mem_en && !prev_en) begin
               // DMA wins only if it waited through MAX_WAIT core grants, or core idle
               exp_dma = p_dma && (!p_cpu || m_starve == MAX_WAIT);
               if (exp_dma) begin
                  m_starve = 0; last_streak = streak; streak = 0;
               end else if (p_dma) begin
                  m_starve = (m_starve == MAX_WAIT) ? MAX_WAIT : m_starve + 1;
                  streak++;
               end else begin
                  m_starve = 0; streak = 0;
               end
               g_cyc = cyc; g_dma = exp_dma; win_addr = mem_addr; addr_moved = 1'b0; en_len = 0;
               chk("grant_queued", 32'(exp_dma ? dma_q.size() != 0 : cpu_q.size() != 0), 32'(1));
               if (exp_dma ? dma_q.size() != 0 : cpu_q.size() != 0) begin
                  t_m = exp_dma ? dma_q[0] : cpu_q[0];
                  chk("grant_addr", 32'(mem_addr), 32'(t_m.addr));
                  chk("grant_we", 32'(mem_we), 32'(t_m.we));
                  if (t_m.we) chk("grant_wdata", 32'(mem_wdata), 32'(t_m.data));
               end
            end
            if (mem_en) begin
               en_len++;
               if (mem_addr !== win_addr) addr_moved = 1'b1;
            end
            if (!mem_en && prev_en) begin
               chk("en_len", 32'(en_len), 32'(MEM_LAT));
               chk("addr_stable", 32'(addr_moved), 32'(0));
            end
            if (cpu_ready) begin
               chk("cpu_ready_queued", 32'(cpu_q.size() != 0), 32'(1));
               chk("cpu_ready_owner", 32'(g_dma), 32'(0));
               if (cpu_q.size() != 0) begin
                  t_m = cpu_q.pop_front();
                  chk("cpu_latency", 32'(cyc - g_cyc), 32'(MEM_LAT));
                  if (t_m.we) chk("cpu_wr_commit", 32'(dev_rd(t_m.addr)), 32'(t_m.data));
                  else        chk("cpu_rdata", 32'(cpu_rdata), 32'(t_m.data));
               end
            end
            if (dma_ack) begin
               chk("dma_ack_queued", 32'(dma_q.size() != 0), 32'(1));
               chk("dma_ack_owner", 32'(g_dma), 32'(1));
               if (dma_q.size() != 0) begin
                  t_m = dma_q.pop_front();
                  chk("dma_latency", 32'(cyc - g_cyc), 32'(MEM_LAT));
                  if (t_m.we) chk("dma_wr_commit", 32'(dev_rd(t_m.addr)), 32'(t_m.data));
                  else        chk("dma_rdata", 32'(dma_rdata), 32'(t_m.data));
               end
            end
            p_cpu   = cpu_rd | cpu_wr;
            p_dma   = dma_req;
            prev_en = mem_en;
         end
      end
   end

   // drivers: called just after a rising edge, return just after a rising edge
   task automatic cpu_txn(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      txn_t t;
      int   n;
      t.we = wr; t.addr = a;
      if (wr) begin t.data = d; ref_mem[int'(a)] = d; end
      else t.data = ref_rd(a);
      cpu_q.push_back(t);
      cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
      n = 0;
      do begin @(negedge mclk); n++; end while (!cpu_ready && n < 200);
      chk("cpu_handshake", 32'(cpu_ready), 32'(1));
      @(posedge mclk); #1;
      cpu_rd = 1'b0; cpu_wr = 1'b0;
   endtask

   task automatic dma_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      txn_t t;
      int   n;
      t.we = we; t.addr = a;
      if (we) begin t.data = d; ref_mem[int'(a)] = d; end
      else t.data = ref_rd(a);
      dma_q.push_back(t);
      dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
      n = 0;
      do begin @(negedge mclk); n++; end while (!dma_ack && n < 200);
      chk("dma_handshake", 32'(dma_ack), 32'(1));
      @(posedge mclk); #1;
      dma_req = 1'b0; dma_we = 1'($urandom);
   endtask

   int n_wait;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge mclk);
      #1;
      chk("rst_ctrl", 32'({cpu_ready, dma_ack, mem_en, mem_we, busy, proto_err}), 32'(0));
      chk("rst_cpu_rdata", 32'(cpu_rdata), 32'(0));
      chk("rst_dma_rdata", 32'(dma_rdata), 32'(0));
      chk("rst_mem_addr", 32'(mem_addr), 32'(0));
      chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
      @(negedge mclk); mrst = 1'b1; mon_en = 1'b1;
      @(posedge mclk); #1;

      // core read, memory returns 1234
      cpu_txn(1'b1, 1'b0, 12'h0A5, 16'h0000);
      // DMA write
      dma_txn(1'b1, 12'h100, 16'hBEEF);
      // simultaneous requests: core first
      fork
         cpu_txn(1'b0, 1'b1, 12'h2AA, 16'h1111);
         dma_txn(1'b0, 12'h9AB, 16'h0000);
      join
      // starvation: continuous core stream against held DMA requests
      fork
         begin
            for (int i = 0; i < 10; i++) cpu_txn(1'b1, 1'b0, 12'(12'h400 + i), 16'h0000);
         end
         begin
            dma_txn(1'b1, 12'hA00, 16'h5555);
            chk("starve_streak_1", 32'(last_streak), 32'(MAX_WAIT));
            dma_txn(1'b1, 12'hA01, 16'h6666);
         end
      join
      chk("starve_streak_2", 32'(last_streak), 32'(MAX_WAIT));

      // rd and wr together: performed as a write, sticky error
      cpu_txn(1'b1, 1'b1, 12'h0C3, 16'hCAFE);
      chk("proto_err_set", 32'(proto_err), 32'(1));
      cpu_txn(1'b1, 1'b0, 12'h0C3, 16'h0000);
      chk("proto_err_sticky", 32'(proto_err), 32'(1));

      // asynchronous reset in the second access cycle
      mon_en = 1'b0;
      cpu_rd = 1'b1; cpu_addr = 12'h300;
      n_wait = 0;
      do begin @(negedge mclk); n_wait++; end while (!mem_en && n_wait < 20);
      chk("t5_access_started", 32'(mem_en), 32'(1));
      @(posedge mclk); #2;
      mrst = 1'b0;
      #1;
      chk("t5_async_en", 32'({mem_en, mem_we}), 32'(0));
      chk("t5_async_busy", 32'(busy), 32'(0));
      chk("t5_async_ready", 32'(cpu_ready), 32'(0));
      cpu_rd = 1'b0;
      cpu_q.delete(); dma_q.delete();
      m_starve = 0; streak = 0;
      @(negedge mclk); mrst = 1'b1;
      repeat (2) @(posedge mclk);
      #1;
      chk("t5_idle_after", 32'(busy), 32'(0));
      chk("t5_proto_cleared", 32'(proto_err), 32'(0));
      mon_en = 1'b1;
      cpu_txn(1'b1, 1'b0, 12'h0A5, 16'h0000);

      // randomized traffic on disjoint address halves
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               logic w;
               w = 1'($urandom);
               cpu_txn(~w, w, 12'($urandom_range(12'h200, 12'h7FF)), 16'($urandom));
               repeat ($urandom_range(0, 3)) begin @(posedge mclk); #1; end
            end
         end
         begin
            for (int j = 0; j < 40; j++) begin
               dma_txn(1'($urandom), 12'($urandom_range(12'h800, 12'hFFF)), 16'($urandom));
               repeat ($urandom_range(0, 3)) begin @(posedge mclk); #1; end
            end
         end
      join

      repeat (10) @(posedge mclk);
      #1;
      chk("cpu_q_drained", 32'(cpu_q.size()), 32'(0));
      chk("dma_q_drained", 32'(dma_q.size()), 32'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
